// File: rtl/fifo_v4.sv
// Circular-buffer FIFO with push/pop semantics, optional fall-through, programmable
// almost-full/almost-empty thresholds, sticky error flags and a high-water mark.
module fifo_v4 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned PTR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic                  err_clr_i,
    input  logic [CNT_WIDTH-1:0]  af_thresh_i,
    input  logic [CNT_WIDTH-1:0]  ae_thresh_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_WIDTH-1:0]  usage_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [CNT_WIDTH-1:0]  hwm_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  hwm_q, hwm_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic count_zero;
    logic count_full;
    logic ft_bypass;
    logic ft_consume;
    logic push_acc;
    logic pop_acc;
    logic write_en;
    logic unused_testmode;

    assign unused_testmode = testmode_i;

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_WIDTH'(1);
    endfunction

    assign count_zero = (count_q == '0);
    assign count_full = (count_q == CNT_WIDTH'(DEPTH));

    // A push into an empty fall-through FIFO is presented on data_o immediately.
    assign ft_bypass  = (FALL_THROUGH == 1'b1) && count_zero && push_i;
    assign ft_consume = ft_bypass && pop_i;

    assign empty_o = count_zero && !ft_bypass;
    assign full_o  = count_full;

    assign push_acc = push_i && !full_o;
    assign pop_acc  = pop_i && !empty_o;
    assign write_en = push_acc && !ft_consume && !flush_i;

    assign data_o         = ft_bypass ? data_i : mem_q[rd_ptr_q];
    assign usage_o        = count_q;
    assign almost_full_o  = (count_q >= af_thresh_i);
    assign almost_empty_o = (count_q <= ae_thresh_i);
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;
    assign hwm_o          = hwm_q;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred; blocking '=' is correct here.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (!ft_consume) begin
            if (push_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Set wins over clear; a push dropped by flush is not an error.
    always_comb begin
        ovf_d = (ovf_q && !err_clr_i) || (push_i && full_o && !flush_i);
        unf_d = (unf_q && !err_clr_i) || (pop_i && empty_o && !flush_i);
        if (err_clr_i) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: storage is reset (not left as plain RAM) because data_o must read
    // zero straight out of reset; flush deliberately leaves the contents alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_fifo_v4.sv
// Directed bench for fifo_v4: three instances cover DEPTH=4 registered, DEPTH=5
// wrap-around and DEPTH=4 fall-through behaviour.
module tb_fifo_v4;

    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          testmode = 1'b0;
    logic [CW-1:0] af_thresh = 3'd3;
    logic [CW-1:0] ae_thresh = 3'd1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DEPTH=4, registered output
    logic          a_flush = 0, a_err_clr = 0, a_push = 0, a_pop = 0;
    logic [DW-1:0] a_data = '0, a_data_o;
    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [CW-1:0] a_usage, a_hwm;

    // DEPTH=5, registered output
    logic          w_flush = 0, w_err_clr = 0, w_push = 0, w_pop = 0;
    logic [DW-1:0] w_data = '0, w_data_o;
    logic          w_full, w_empty, w_af, w_ae, w_ovf, w_unf;
    logic [CW-1:0] w_usage, w_hwm;

    // DEPTH=4, fall-through
    logic          f_flush = 0, f_err_clr = 0, f_push = 0, f_pop = 0;
    logic [DW-1:0] f_data = '0, f_data_o;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_usage, f_hwm;

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b0)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(testmode),
        .err_clr_i(a_err_clr), .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
        .data_i(a_data), .push_i(a_push), .pop_i(a_pop), .data_o(a_data_o),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ovf),
        .underflow_o(a_unf), .hwm_o(a_hwm)
    );

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(5), .FALL_THROUGH(1'b0)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(w_flush), .testmode_i(testmode),
        .err_clr_i(w_err_clr), .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
        .data_i(w_data), .push_i(w_push), .pop_i(w_pop), .data_o(w_data_o),
        .full_o(w_full), .empty_o(w_empty), .usage_o(w_usage),
        .almost_full_o(w_af), .almost_empty_o(w_ae), .overflow_o(w_ovf),
        .underflow_o(w_unf), .hwm_o(w_hwm)
    );

    fifo_v4 #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b1)) u_dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush), .testmode_i(testmode),
        .err_clr_i(f_err_clr), .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
        .data_i(f_data), .push_i(f_push), .pop_i(f_pop), .data_o(f_data_o),
        .full_o(f_full), .empty_o(f_empty), .usage_o(f_usage),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .overflow_o(f_ovf),
        .underflow_o(f_unf), .hwm_o(f_hwm)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", a_full); end
        checks++; if (a_usage !== 3'd0) begin errors++; $display("FAIL reset_usage got %0d exp 0", a_usage); end
        checks++; if (a_data_o !== 16'h0) begin errors++; $display("FAIL reset_data got %h exp 0000", a_data_o); end
        checks++; if (a_hwm !== 3'd0) begin errors++; $display("FAIL reset_hwm got %0d exp 0", a_hwm); end
        checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {a_ovf, a_unf}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        vals[0] = 16'hA000; vals[1] = 16'hB111; vals[2] = 16'hC222; vals[3] = 16'hD333;
        a_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = vals[i];
            tick();
        end
        a_push = 1'b0;
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", a_full); end
        checks++; if (a_usage !== 3'd4) begin errors++; $display("FAIL fill_usage got %0d exp 4", a_usage); end
        checks++; if (a_hwm !== 3'd4) begin errors++; $display("FAIL fill_hwm got %0d exp 4", a_hwm); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_data_o !== vals[i]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, a_data_o, vals[i]); end
            a_pop = 1'b1;
            tick();
        end
        a_pop = 1'b0;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", a_empty); end
        checks++; if (a_usage !== 3'd0) begin errors++; $display("FAIL drain_usage got %0d exp 0", a_usage); end
    endtask

    task automatic test_wrap();
        w_push = 1'b1;
        w_data = 16'd100; tick();
        w_data = 16'd101; tick();
        w_pop = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w_data = DW'(102 + i);
            #1;
            checks++; if (w_data_o !== DW'(100 + i)) begin errors++; $display("FAIL wrap_data[%0d] got %0d exp %0d", i, w_data_o, 100 + i); end
            checks++; if (w_usage !== 3'd2) begin errors++; $display("FAIL wrap_usage[%0d] got %0d exp 2", i, w_usage); end
            tick();
        end
        w_push = 1'b0;
        w_pop  = 1'b0;
        #1;
        checks++; if (w_usage !== 3'd2) begin errors++; $display("FAIL wrap_usage_end got %0d exp 2", w_usage); end
        checks++; if (w_data_o !== 16'd112) begin errors++; $display("FAIL wrap_head_end got %0d exp 112", w_data_o); end
    endtask

    task automatic test_fall_through();
        f_push = 1'b1; f_pop = 1'b1; f_data = 16'hCAFE;
        #1;
        checks++; if (f_data_o !== 16'hCAFE) begin errors++; $display("FAIL ft_data got %h exp cafe", f_data_o); end
        checks++; if (f_empty !== 1'b0) begin errors++; $display("FAIL ft_empty got %b exp 0", f_empty); end
        tick();
        f_push = 1'b0; f_pop = 1'b0;
        #1;
        checks++; if (f_usage !== 3'd0) begin errors++; $display("FAIL ft_consume_usage got %0d exp 0", f_usage); end
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL ft_consume_empty got %b exp 1", f_empty); end
        checks++; if (f_unf !== 1'b0) begin errors++; $display("FAIL ft_consume_unf got %b exp 0", f_unf); end
        f_push = 1'b1; f_data = 16'hBEEF;
        #1;
        checks++; if (f_data_o !== 16'hBEEF) begin errors++; $display("FAIL ft_push_data got %h exp beef", f_data_o); end
        tick();
        f_push = 1'b0;
        #1;
        checks++; if (f_usage !== 3'd1) begin errors++; $display("FAIL ft_push_usage got %0d exp 1", f_usage); end
        checks++; if (f_data_o !== 16'hBEEF) begin errors++; $display("FAIL ft_stored_data got %h exp beef", f_data_o); end
        f_pop = 1'b1;
        tick();
        f_pop = 1'b0;
        checks++; if (f_empty !== 1'b1) begin errors++; $display("FAIL ft_pop_empty got %b exp 1", f_empty); end
    endtask

    task automatic test_errors();
        a_push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = DW'(16'h0011 * (i + 1));
            tick();
        end
        a_data = 16'h9999;
        tick();
        a_push = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", a_ovf); end
        checks++; if (a_usage !== 3'd4) begin errors++; $display("FAIL ovf_usage got %0d exp 4", a_usage); end
        checks++; if (a_data_o !== 16'h0011) begin errors++; $display("FAIL ovf_head got %h exp 0011", a_data_o); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b exp 1", i, a_ovf); end
        end
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", a_ovf); end
        checks++; if (a_hwm !== 3'd4) begin errors++; $display("FAIL hwm_after_clr got %0d exp 4", a_hwm); end
        a_pop = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_before got %b exp 0", a_unf); end
        tick();
        a_pop = 1'b0;
        checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", a_unf); end
    endtask

    task automatic test_thresholds();
        for (int i = 0; i <= 4; i++) begin
            checks++; if (a_usage !== CW'(i)) begin errors++; $display("FAIL thr_usage[%0d] got %0d exp %0d", i, a_usage, i); end
            checks++; if (a_ae !== (i <= 1)) begin errors++; $display("FAIL thr_ae[%0d] got %b exp %b", i, a_ae, (i <= 1)); end
            checks++; if (a_af !== (i >= 3)) begin errors++; $display("FAIL thr_af[%0d] got %b exp %b", i, a_af, (i >= 3)); end
            if (i < 4) begin
                a_push = 1'b1; a_data = DW'(16'h0100 + i);
                tick();
                a_push = 1'b0;
            end
        end
        a_pop = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        a_pop = 1'b0;
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        checks++; if (a_hwm !== 3'd0) begin errors++; $display("FAIL hwm_reload got %0d exp 0", a_hwm); end
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", a_unf); end
    endtask

    task automatic test_flush_and_reset();
        a_push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = DW'(16'h0200 + i);
            tick();
        end
        checks++; if (a_usage !== 3'd3) begin errors++; $display("FAIL pre_flush_usage got %0d exp 3", a_usage); end
        a_flush = 1'b1; a_data = 16'h5555;
        tick();
        a_flush = 1'b0; a_push = 1'b0;
        checks++; if (a_usage !== 3'd0) begin errors++; $display("FAIL flush_usage got %0d exp 0", a_usage); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", a_empty); end
        checks++; if (a_hwm !== 3'd3) begin errors++; $display("FAIL flush_hwm got %0d exp 3", a_hwm); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b exp 0", a_ovf); end
        a_pop = 1'b1;
        tick();
        a_pop = 1'b0;
        a_push = 1'b1;
        a_data = 16'h0077; tick();
        a_data = 16'h0088; tick();
        a_push = 1'b0;
        checks++; if (a_data_o !== 16'h0077) begin errors++; $display("FAIL post_flush_head got %h exp 0077", a_data_o); end
        checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL pre_rst_unf got %b exp 1", a_unf); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b exp 1", a_empty); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL arst_full got %b exp 0", a_full); end
        checks++; if (a_usage !== 3'd0) begin errors++; $display("FAIL arst_usage got %0d exp 0", a_usage); end
        checks++; if (a_data_o !== 16'h0) begin errors++; $display("FAIL arst_data got %h exp 0000", a_data_o); end
        checks++; if (a_hwm !== 3'd0) begin errors++; $display("FAIL arst_hwm got %0d exp 0", a_hwm); end
        checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL arst_unf got %b exp 0", a_unf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_fall_through();
        test_errors();
        test_thresholds();
        test_flush_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
